// File: rtl/median_3x3_window_ctrl.sv
// median_3x3_window_ctrl: raster-stream sequencer feeding zero-padded 3x3 windows to a median calc unit
module median_3x3_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [DW-1:0] pixel_i,
  input  logic          pixel_valid_i,
  output logic          pixel_ready_o,
  output logic          calc_start_o,
  output logic [DW-1:0] S1,
  output logic [DW-1:0] S2,
  output logic [DW-1:0] S3,
  output logic [DW-1:0] S4,
  output logic [DW-1:0] S5,
  output logic [DW-1:0] S6,
  output logic [DW-1:0] S7,
  output logic [DW-1:0] S8,
  output logic [DW-1:0] S9,
  input  logic          calc_done_i,
  input  logic [DW-1:0] calc_median_i,
  output logic [DW-1:0] median_o,
  output logic          median_valid_o,
  output logic          frame_done_o,
  output logic          busy_o
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GAP, DONE} state_t;
  state_t state;
  logic [RW-1:0] in_row, out_r, tr;
  logic [CW-1:0] in_col, out_c, tc;
  logic [1:0] in_line, out_line;
  logic in_full, sat, acc, go, last_out, last_in, in_eol, out_eol;
  logic [DW-1:0] mem [3][IMG_W];
  logic [DW-1:0] s_q [9];
  logic [DW-1:0] win [9];
  logic [RW-1:0] trow [3];
  logic [CW-1:0] tcol [3];
  logic [1:0] tline [3];
  logic [2:0] rv, cv;
  assign {S1, S2, S3, S4, S5, S6, S7, S8, S9} = {s_q[0], s_q[1], s_q[2], s_q[3], s_q[4], s_q[5], s_q[6], s_q[7], s_q[8]};
  // window target pixel, input gating and padded tap selection (the incoming pixel bypasses the buffer)
  always_comb begin
    tr = (out_r == RW'(IMG_H-1)) ? out_r : out_r + RW'(1);
    tc = (out_c == CW'(IMG_W-1)) ? out_c : out_c + CW'(1);
    sat = in_full || in_row > tr || (in_row == tr && in_col > tc);
    pixel_ready_o = state == LOAD && !sat;
    acc = pixel_valid_i && pixel_ready_o;
    go = sat || (acc && in_row == tr && in_col == tc);
    in_eol = in_col == CW'(IMG_W-1);
    out_eol = out_c == CW'(IMG_W-1);
    last_in = in_eol && in_row == RW'(IMG_H-1);
    last_out = out_eol && out_r == RW'(IMG_H-1);
    trow = '{out_r - RW'(1), out_r, out_r + RW'(1)};
    tcol = '{out_c - CW'(1), out_c, out_c + CW'(1)};
    tline = '{out_line == 2'd0 ? 2'd2 : out_line - 2'd1, out_line, out_line == 2'd2 ? 2'd0 : out_line + 2'd1};
    rv = {out_r != RW'(IMG_H-1), 1'b1, out_r != '0};
    cv = {out_eol == 1'b0, 1'b1, out_c != '0};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win[i*3+j] = !(rv[i] && cv[j]) ? '0 :
                     (acc && trow[i] == in_row && tcol[j] == in_col) ? pixel_i : mem[tline[i]][tcol[j]];
  end
  // three rotating line buffers, written at (in_row mod 3, in_col)
  always_ff @(posedge clk)
    if (acc) mem[in_line][in_col] <= pixel_i;
  // frame sequencer with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      calc_start_o <= 1'b0;
      median_o <= '0;
      median_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o <= 1'b0;
      s_q <= '{default: '0};
      in_row <= '0;
      in_col <= '0;
      in_line <= '0;
      out_r <= '0;
      out_c <= '0;
      out_line <= '0;
      in_full <= 1'b0;
    end else begin
      median_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      if (acc) begin
        in_col <= in_eol ? '0 : in_col + CW'(1);
        in_row <= in_eol ? (last_in ? '0 : in_row + RW'(1)) : in_row;
        in_line <= in_eol ? (in_line == 2'd2 ? 2'd0 : in_line + 2'd1) : in_line;
        in_full <= in_full || last_in;
      end
      case (state)
        IDLE: if (start_i) begin
          state <= LOAD;
          busy_o <= 1'b1;
          in_row <= '0;
          in_col <= '0;
          in_line <= '0;
          out_r <= '0;
          out_c <= '0;
          out_line <= '0;
          in_full <= 1'b0;
        end
        LOAD: if (go) begin
          state <= ISSUE;
          calc_start_o <= 1'b1;
          s_q <= win;
        end
        ISSUE: if (calc_done_i) begin
          state <= GAP;
          calc_start_o <= 1'b0;
          median_o <= calc_median_i;
          median_valid_o <= 1'b1;
        end
        GAP: if (!calc_done_i) begin
          state <= last_out ? DONE : LOAD;
          frame_done_o <= last_out;
          busy_o <= !last_out;
          out_c <= out_eol ? '0 : out_c + CW'(1);
          out_r <= out_eol ? out_r + RW'(1) : out_r;
          out_line <= out_eol ? (out_line == 2'd2 ? 2'd0 : out_line + 2'd1) : out_line;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_median_3x3_window_ctrl.sv
// tb_median_3x3_window_ctrl: directed table-driven bench with a behavioural median calc model
module tb_median_3x3_window_ctrl;
  logic clk = 0, rst = 0, start_i = 0, pixel_valid_i = 0, calc_done_i;
  logic [7:0] pixel_i = 0, calc_median_i, median_o;
  logic pixel_ready_o, calc_start_o, median_valid_o, frame_done_o, busy_o;
  logic [7:0] S1, S2, S3, S4, S5, S6, S7, S8, S9;
  logic [8:0][7:0] sv;
  assign sv = {S9, S8, S7, S6, S5, S4, S3, S2, S1};

  median_3x3_window_ctrl #(.IMG_W(3), .IMG_H(3), .DW(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i),
    .pixel_ready_o(pixel_ready_o), .calc_start_o(calc_start_o),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6), .S7(S7), .S8(S8), .S9(S9),
    .calc_done_i(calc_done_i), .calc_median_i(calc_median_i), .median_o(median_o),
    .median_valid_o(median_valid_o), .frame_done_o(frame_done_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  int checks = 0, errs = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] med9(input logic [8:0][7:0] a);
    logic [7:0] t;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[4];
  endfunction

  function automatic logic [8:0][7:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [8:0][7:0] r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3); r[4] = 8'(a4);
    r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7); r[8] = 8'(a8);
    return r;
  endfunction

  // calc model: done 3 cycles after start, drops after start falls plus 'extra' stuck cycles
  logic cdone_m = 0, done_force = 0;
  logic [7:0] cmed = 0;
  int ccnt = 0, chold = 0, extra = 0;
  assign calc_done_i = cdone_m | done_force;
  assign calc_median_i = cmed;
  always @(posedge clk) begin
    if (calc_start_o) begin
      chold <= 0;
      if (!cdone_m) begin
        if (ccnt == 2) begin cdone_m <= 1; cmed <= med9(sv); ccnt <= 0; end
        else ccnt <= ccnt + 1;
      end
    end else begin
      ccnt <= 0;
      if (cdone_m) begin
        if (chold < extra) chold <= chold + 1;
        else begin cdone_m <= 0; chold <= 0; end
      end
    end
  end

  // monitor
  int nmed = 0, nfd = 0, nacc = 0, nwin = 0, viol = 0, fd_nmed = 0, fd_busy = 0;
  logic [7:0] medq[$], accq[$];
  logic [8:0][7:0] wins [16];
  int winacc [16], winprev [16];
  bit prev_start = 0, prev_acc = 0, abort = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (median_valid_o) begin medq.push_back(median_o); nmed++; end
      if (frame_done_o) begin nfd++; fd_nmed = nmed; fd_busy = busy_o; end
      if (pixel_ready_o && (calc_start_o || calc_done_i)) viol++;
      if (calc_start_o && !prev_start) begin
        if (calc_done_i) viol++;
        if (nwin < 16) begin wins[nwin] = sv; winacc[nwin] = nacc; winprev[nwin] = prev_acc; end
        nwin++;
      end
      prev_acc = pixel_valid_i && pixel_ready_o;
      if (prev_acc) begin nacc++; accq.push_back(pixel_i); end
    end
    prev_start = calc_start_o;
  end

  task automatic send(input logic [8:0][7:0] p, input bit gaps);
    for (int i = 0; i < 9 && !abort; i++) begin
      bit v;
      int t = 0;
      pixel_i = p[i];
      pixel_valid_i = gaps ? 1'($urandom % 2) : 1'b1;
      do begin
        @(negedge clk);
        v = pixel_valid_i && pixel_ready_o;
        @(posedge clk); #1;
        t++;
        if (!v && gaps) pixel_valid_i = 1'($urandom % 2);
      end while (!v && !abort && t < 500);
      if (!v && !abort) chk("pixel_accept_timeout", 0, 1);
    end
    pixel_valid_i = 0;
  endtask

  // mode 0: plain frame, 1: start pulsed mid-frame, 2: reset after the 3rd median
  task automatic run_frame(input logic [8:0][7:0] p, input bit gaps, input int ex, input int mode);
    medq.delete(); accq.delete();
    nmed = 0; nfd = 0; nacc = 0; nwin = 0; viol = 0; fd_nmed = 0; fd_busy = 1;
    extra = ex; abort = 0;
    @(posedge clk); #1 start_i = 1;
    @(posedge clk); #1 start_i = 0;
    chk("busy_after_start", busy_o, 1);
    chk("ready_after_start", pixel_ready_o, 1);
    fork
      send(p, gaps);
      begin
        int t = 0;
        if (mode == 2) begin
          while (nmed < 3 && t < 2000) begin @(negedge clk); t++; end
          chk("third_median_seen", nmed, 3);
          @(posedge clk); #1 rst = 0;
          @(posedge clk); #1 rst = 1; abort = 1; done_force = 1;
          begin
            int bad = 0;
            for (int k = 0; k < 6; k++) begin
              @(negedge clk);
              if (median_valid_o || calc_start_o || busy_o || frame_done_o) bad++;
            end
            chk("late_done_ignored", bad, 0);
          end
          done_force = 0;
        end else begin
          while (nfd == 0 && t < 2000) begin
            @(negedge clk);
            t++;
            if (mode == 1) start_i = (t == 30);
          end
          start_i = 0;
          chk("frame_done_seen", nfd, 1);
        end
      end
    join
    repeat (8) @(negedge clk);
  endtask

  typedef struct packed {
    logic [8:0][7:0] pix, med, s0, s4, s8;
    logic gaps;
    logic [2:0] extra;
  } vec_t;
  vec_t tv [4];

  task automatic check_frame(input int v, input vec_t e);
    chk($sformatf("v%0d_n_median", v), nmed, 9);
    chk($sformatf("v%0d_n_window", v), nwin, 9);
    chk($sformatf("v%0d_n_frame_done", v), nfd, 1);
    chk($sformatf("v%0d_fd_after_last", v), fd_nmed, 9);
    chk($sformatf("v%0d_fd_busy", v), fd_busy, 0);
    chk($sformatf("v%0d_ready_viol", v), viol, 0);
    chk($sformatf("v%0d_n_accept", v), nacc, 9);
    chk($sformatf("v%0d_first_issue_acc", v), winacc[0], 5);
    chk($sformatf("v%0d_first_issue_noready", v), winprev[0], 1);
    for (int i = 0; i < 9; i++) begin
      if (i < medq.size()) chk($sformatf("v%0d_median%0d", v, i), medq[i], e.med[i]);
      if (i < accq.size()) chk($sformatf("v%0d_pixel%0d", v, i), accq[i], e.pix[i]);
      chk($sformatf("v%0d_w0_s%0d", v, i + 1), wins[0][i], e.s0[i]);
      chk($sformatf("v%0d_w4_s%0d", v, i + 1), wins[4][i], e.s4[i]);
      chk($sformatf("v%0d_w8_s%0d", v, i + 1), wins[8][i], e.s8[i]);
    end
  endtask

  initial begin
    tv[0].pix = mk(1, 2, 3, 4, 5, 6, 7, 8, 9);
    tv[0].med = mk(0, 2, 0, 2, 5, 3, 0, 5, 0);
    tv[0].s0 = mk(0, 0, 0, 0, 1, 2, 0, 4, 5);
    tv[0].s4 = mk(1, 2, 3, 4, 5, 6, 7, 8, 9);
    tv[0].s8 = mk(5, 6, 0, 8, 9, 0, 0, 0, 0);
    tv[0].gaps = 0; tv[0].extra = 0;
    tv[1].pix = mk(20, 90, 60, 30, 10, 70, 50, 40, 80);
    tv[1].med = mk(0, 20, 0, 20, 50, 40, 0, 30, 0);
    tv[1].s0 = mk(0, 0, 0, 0, 20, 90, 0, 30, 10);
    tv[1].s4 = mk(20, 90, 60, 30, 10, 70, 50, 40, 80);
    tv[1].s8 = mk(10, 70, 0, 40, 80, 0, 0, 0, 0);
    tv[1].gaps = 0; tv[1].extra = 0;
    tv[2] = tv[0]; tv[2].gaps = 1;
    tv[3] = tv[0]; tv[3].extra = 4;

    rst = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start_i = 1; pixel_valid_i = 1'($urandom % 2); pixel_i = 8'($urandom); done_force = 1'($urandom % 2);
    end
    @(negedge clk);
    chk("rst_ready", pixel_ready_o, 0);
    chk("rst_calc_start", calc_start_o, 0);
    chk("rst_s_all", int'(|sv), 0);
    chk("rst_median", median_o, 0);
    chk("rst_median_valid", median_valid_o, 0);
    chk("rst_frame_done", frame_done_o, 0);
    chk("rst_busy", busy_o, 0);
    @(posedge clk); #1;
    rst = 1; start_i = 0; pixel_valid_i = 0; done_force = 0;
    @(negedge clk);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_ready", pixel_ready_o, 0);

    for (int v = 0; v < 4; v++) begin
      run_frame(tv[v].pix, tv[v].gaps, int'(tv[v].extra), 0);
      check_frame(v, tv[v]);
    end
    run_frame(tv[0].pix, 0, 0, 2);
    run_frame(tv[1].pix, 0, 0, 1);
    check_frame(5, tv[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
